// File: rtl/cache_def.sv
// ============================================================================
// cache_def : shared L1 cache geometry and victim-controller state encoding
// Revision  : 1.0
// ============================================================================
`default_nettype none

package cache_def;

    localparam int INDEX_L1     = 6;
    localparam int INDEX_WAY_L1 = 2;
    localparam int TAG_L1       = 20;
    localparam int BEATS        = 4;
    localparam int BEAT_W       = $clog2(BEATS);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOOKUP  = 3'd1,
        ST_WB      = 3'd2,
        ST_RF_REQ  = 3'd3,
        ST_RF_DATA = 3'd4,
        ST_UPDATE  = 3'd5,
        ST_DONE    = 3'd6
    } cache_victim_state_e;

endpackage

`default_nettype wire

// File: rtl/cache_victim_beat_cnt.sv
// ============================================================================
// cache_victim_beat_cnt : wrapping line-beat counter with clear and last flag
// Revision              : 1.0
// ============================================================================
`default_nettype none

module cache_victim_beat_cnt #(
    parameter int BEATS = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clr_i,
    input  logic                     inc_i,
    output logic [$clog2(BEATS)-1:0] cnt_o,
    output logic                     last_o
);

    localparam int BEAT_W = $clog2(BEATS);

    logic [BEAT_W-1:0] r_cnt;

    // Natural wrap at BEATS-1 leaves the counter at 0 for the next burst.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (clr_i) begin
            r_cnt <= '0;
        end else if (inc_i) begin
            r_cnt <= r_cnt + BEAT_W'(1);
        end
    end

    assign cnt_o  = r_cnt;
    assign last_o = (r_cnt == BEAT_W'(BEATS - 1));

endmodule

`default_nettype wire

// File: rtl/cache_victim_ctrl.sv
// ============================================================================
// cache_victim_ctrl : L1 miss replacement - victim writeback, burst refill,
//                     tag rewrite and pLRU touch
// Revision          : 1.0
// ============================================================================
`default_nettype none

module cache_victim_ctrl #(
    parameter int INDEX_W = cache_def::INDEX_L1,
    parameter int WAY_W   = cache_def::INDEX_WAY_L1,
    parameter int TAG_W   = cache_def::TAG_L1,
    parameter int BEATS   = cache_def::BEATS,
    parameter int DATA_W  = 32
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    input  logic                                     req_valid_i,
    output logic                                     req_ready_o,
    input  logic [INDEX_W-1:0]                       req_index_i,
    input  logic [TAG_W-1:0]                         req_tag_i,
    input  logic [WAY_W-1:0]                         victim_way_i,
    input  logic                                     victim_valid_i,
    input  logic                                     victim_dirty_i,
    input  logic [TAG_W-1:0]                         victim_tag_i,
    input  logic [DATA_W-1:0]                        wb_data_i,
    output logic [INDEX_W-1:0]                       arr_index_o,
    output logic [WAY_W-1:0]                         arr_way_o,
    output logic [$clog2(BEATS)-1:0]                 arr_beat_o,
    output logic                                     arr_we_o,
    output logic [DATA_W-1:0]                        arr_wdata_o,
    output logic                                     tag_we_o,
    output logic                                     mem_req_valid_o,
    input  logic                                     mem_req_ready_i,
    output logic                                     mem_we_o,
    output logic [TAG_W+INDEX_W+$clog2(BEATS)-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]                        mem_wdata_o,
    input  logic                                     mem_rvalid_i,
    input  logic [DATA_W-1:0]                        mem_rdata_i,
    output logic                                     plru_valid_o,
    output logic [INDEX_W-1:0]                       plru_index_o,
    output logic [WAY_W-1:0]                         plru_way_o,
    output logic                                     done_o
);

    import cache_def::*;

    localparam int BEAT_W = $clog2(BEATS);
    localparam int ADDR_W = TAG_W + INDEX_W + BEAT_W;

    cache_victim_state_e r_state;
    logic [INDEX_W-1:0]  r_index;
    logic [TAG_W-1:0]    r_tag;
    logic [TAG_W-1:0]    r_victim_tag;
    logic [WAY_W-1:0]    r_way;

    logic                w_beat_clr;
    logic                w_beat_inc;
    logic                w_beat_last;
    logic [BEAT_W-1:0]   w_beat;
    logic                w_in_wb;
    logic                w_in_rf_req;
    logic                w_in_update;

    assign w_in_wb     = (r_state == ST_WB);
    assign w_in_rf_req = (r_state == ST_RF_REQ);
    assign w_in_update = (r_state == ST_UPDATE);

    // One counter serves both the writeback and refill bursts.
    assign w_beat_clr = (r_state == ST_LOOKUP) || (w_in_rf_req && mem_req_ready_i);
    assign w_beat_inc = (w_in_wb && mem_req_ready_i) || arr_we_o;

    cache_victim_beat_cnt #(
        .BEATS (BEATS)
    ) u_beat_cnt (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (w_beat_clr),
        .inc_i  (w_beat_inc),
        .cnt_o  (w_beat),
        .last_o (w_beat_last)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= ST_IDLE;
            r_index      <= '0;
            r_tag        <= '0;
            r_way        <= '0;
            r_victim_tag <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        r_index <= req_index_i;
                        r_tag   <= req_tag_i;
                        r_way   <= victim_way_i;
                        r_state <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    r_victim_tag <= victim_tag_i;
                    // An invalid entry never needs writeback, whatever its dirty bit.
                    r_state      <= (victim_valid_i && victim_dirty_i) ? ST_WB : ST_RF_REQ;
                end
                ST_WB: begin
                    if (mem_req_ready_i && w_beat_last) begin
                        r_state <= ST_RF_REQ;
                    end
                end
                ST_RF_REQ: begin
                    if (mem_req_ready_i) begin
                        r_state <= ST_RF_DATA;
                    end
                end
                ST_RF_DATA: begin
                    if (mem_rvalid_i && w_beat_last) begin
                        r_state <= ST_UPDATE;
                    end
                end
                ST_UPDATE: r_state <= ST_DONE;
                ST_DONE:   r_state <= ST_IDLE;
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready_o     = (r_state == ST_IDLE);
    assign done_o          = (r_state == ST_DONE);

    assign arr_index_o     = r_index;
    assign arr_way_o       = r_way;
    assign arr_beat_o      = w_beat;
    assign arr_we_o        = (r_state == ST_RF_DATA) && mem_rvalid_i;
    assign arr_wdata_o     = arr_we_o ? mem_rdata_i : '0;

    assign tag_we_o        = w_in_update;
    assign plru_valid_o    = w_in_update;
    assign plru_index_o    = w_in_update ? r_index : '0;
    assign plru_way_o      = w_in_update ? r_way   : '0;

    assign mem_req_valid_o = w_in_wb || w_in_rf_req;
    assign mem_we_o        = w_in_wb;
    assign mem_wdata_o     = w_in_wb ? wb_data_i : '0;
    assign mem_addr_o      = w_in_wb     ? {r_victim_tag, r_index, w_beat} :
                             w_in_rf_req ? {r_tag, r_index, {BEAT_W{1'b0}}} :
                                           ADDR_W'(0);

endmodule

`default_nettype wire

// File: tb/tb_cache_victim_ctrl.sv
// ============================================================================
// tb_cache_victim_ctrl : directed self-checking bench for cache_victim_ctrl
// Revision             : 1.0
// ============================================================================
`default_nettype none

module tb_cache_victim_ctrl;

    localparam int INDEX_W = 6;
    localparam int WAY_W   = 2;
    localparam int TAG_W   = 20;
    localparam int BEATS   = 4;
    localparam int BEAT_W  = 2;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = TAG_W + INDEX_W + BEAT_W;

    logic                clk_i = 1'b0;
    logic                rst_i;
    logic                req_valid_i;
    logic                req_ready_o;
    logic [INDEX_W-1:0]  req_index_i;
    logic [TAG_W-1:0]    req_tag_i;
    logic [WAY_W-1:0]    victim_way_i;
    logic                victim_valid_i;
    logic                victim_dirty_i;
    logic [TAG_W-1:0]    victim_tag_i;
    logic [DATA_W-1:0]   wb_data_i;
    logic [INDEX_W-1:0]  arr_index_o;
    logic [WAY_W-1:0]    arr_way_o;
    logic [BEAT_W-1:0]   arr_beat_o;
    logic                arr_we_o;
    logic [DATA_W-1:0]   arr_wdata_o;
    logic                tag_we_o;
    logic                mem_req_valid_o;
    logic                mem_req_ready_i;
    logic                mem_we_o;
    logic [ADDR_W-1:0]   mem_addr_o;
    logic [DATA_W-1:0]   mem_wdata_o;
    logic                mem_rvalid_i;
    logic [DATA_W-1:0]   mem_rdata_i;
    logic                plru_valid_o;
    logic [INDEX_W-1:0]  plru_index_o;
    logic [WAY_W-1:0]    plru_way_o;
    logic                done_o;

    int nchk = 0;
    int nerr = 0;

    always #5 clk_i = ~clk_i;

    cache_victim_ctrl #(
        .INDEX_W (INDEX_W),
        .WAY_W   (WAY_W),
        .TAG_W   (TAG_W),
        .BEATS   (BEATS),
        .DATA_W  (DATA_W)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_index_i     (req_index_i),
        .req_tag_i       (req_tag_i),
        .victim_way_i    (victim_way_i),
        .victim_valid_i  (victim_valid_i),
        .victim_dirty_i  (victim_dirty_i),
        .victim_tag_i    (victim_tag_i),
        .wb_data_i       (wb_data_i),
        .arr_index_o     (arr_index_o),
        .arr_way_o       (arr_way_o),
        .arr_beat_o      (arr_beat_o),
        .arr_we_o        (arr_we_o),
        .arr_wdata_o     (arr_wdata_o),
        .tag_we_o        (tag_we_o),
        .mem_req_valid_o (mem_req_valid_o),
        .mem_req_ready_i (mem_req_ready_i),
        .mem_we_o        (mem_we_o),
        .mem_addr_o      (mem_addr_o),
        .mem_wdata_o     (mem_wdata_o),
        .mem_rvalid_i    (mem_rvalid_i),
        .mem_rdata_i     (mem_rdata_i),
        .plru_valid_o    (plru_valid_o),
        .plru_index_o    (plru_index_o),
        .plru_way_o      (plru_way_o),
        .done_o          (done_o)
    );

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Drives one complete miss and checks every cycle against the expected sequence.
    task automatic do_miss(input logic [INDEX_W-1:0] idx, input logic [TAG_W-1:0] tag,
                           input logic [WAY_W-1:0] way, input logic vvalid, input logic vdirty,
                           input logic [TAG_W-1:0] vtag, input int wb_stall_beat,
                           input bit rf_stall, input bit gapped, input bit stray);
        logic [ADDR_W-1:0] exp_addr;
        logic [DATA_W-1:0] exp_data;
        logic [BEAT_W-1:0] bb;
        int                nstall;

        mem_req_ready_i = 1'b1;
        mem_rvalid_i    = 1'b0;
        req_valid_i     = 1'b1;
        req_index_i     = idx;
        req_tag_i       = tag;
        victim_way_i    = way;
        #1;
        nchk++;
        if (req_ready_o !== 1'b1) begin
            nerr++;
            $display("FAIL accept_ready: got %b want 1", req_ready_o);
        end
        step();

        // LOOKUP: victim way input now changes; the latched way must be used.
        req_valid_i    = 1'b0;
        victim_way_i   = ~way;
        victim_valid_i = vvalid;
        victim_dirty_i = vdirty;
        victim_tag_i   = vtag;
        if (stray) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = 32'hDEAD_BEEF;
        end
        #1;
        nchk++;
        if ({arr_index_o, arr_way_o, arr_we_o, mem_req_valid_o, req_ready_o} !== {idx, way, 3'b000}) begin
            nerr++;
            $display("FAIL lookup: got idx=%h way=%h we=%b mv=%b rdy=%b want idx=%h way=%h zeros",
                     arr_index_o, arr_way_o, arr_we_o, mem_req_valid_o, req_ready_o, idx, way);
        end
        step();
        mem_rvalid_i = 1'b0;

        if (vvalid && vdirty) begin
            for (int b = 0; b < BEATS; b++) begin
                bb       = BEAT_W'(b);
                exp_addr = {vtag, idx, bb};
                exp_data = 32'hB000_0000 | {idx, way, bb};
                wb_data_i = exp_data;
                nstall = (b == wb_stall_beat) ? 3 : 0;
                for (int s = 0; s <= nstall; s++) begin
                    mem_req_ready_i = (s == nstall);
                    #1;
                    nchk++;
                    if ({mem_req_valid_o, mem_we_o, mem_addr_o, mem_wdata_o, arr_beat_o}
                        !== {2'b11, exp_addr, exp_data, bb}) begin
                        nerr++;
                        $display("FAIL wb beat %0d stall %0d: got v=%b we=%b addr=%h wd=%h ab=%0d want addr=%h wd=%h ab=%0d",
                                 b, s, mem_req_valid_o, mem_we_o, mem_addr_o, mem_wdata_o, arr_beat_o,
                                 exp_addr, exp_data, bb);
                    end
                    step();
                end
            end
        end

        exp_addr = {tag, idx, {BEAT_W{1'b0}}};
        nstall = rf_stall ? 3 : 0;
        for (int s = 0; s <= nstall; s++) begin
            mem_req_ready_i = (s == nstall);
            #1;
            nchk++;
            if ({mem_req_valid_o, mem_we_o, mem_addr_o} !== {2'b10, exp_addr}) begin
                nerr++;
                $display("FAIL rf_req stall %0d: got v=%b we=%b addr=%h want v=1 we=0 addr=%h",
                         s, mem_req_valid_o, mem_we_o, mem_addr_o, exp_addr);
            end
            step();
        end
        mem_req_ready_i = 1'b1;

        for (int b = 0; b < BEATS; b++) begin
            bb = BEAT_W'(b);
            if (gapped && (b % 2 == 1)) begin
                mem_rvalid_i = 1'b0;
                #1;
                nchk++;
                if ({arr_we_o, mem_req_valid_o, tag_we_o} !== 3'b000) begin
                    nerr++;
                    $display("FAIL rf_gap before beat %0d: got we=%b mv=%b tw=%b want 000",
                             b, arr_we_o, mem_req_valid_o, tag_we_o);
                end
                step();
            end
            exp_data     = 32'hC0DE_0000 | {idx, way, bb};
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = exp_data;
            #1;
            nchk++;
            if ({arr_we_o, arr_beat_o, arr_wdata_o, arr_way_o, arr_index_o}
                !== {1'b1, bb, exp_data, way, idx}) begin
                nerr++;
                $display("FAIL rf_data beat %0d: got we=%b ab=%0d wd=%h way=%h idx=%h want we=1 ab=%0d wd=%h way=%h idx=%h",
                         b, arr_we_o, arr_beat_o, arr_wdata_o, arr_way_o, arr_index_o,
                         bb, exp_data, way, idx);
            end
            step();
        end
        mem_rvalid_i = 1'b0;

        #1;
        nchk++;
        if ({tag_we_o, plru_valid_o, plru_index_o, plru_way_o, done_o, arr_we_o}
            !== {2'b11, idx, way, 2'b00}) begin
            nerr++;
            $display("FAIL update: got tw=%b pv=%b pidx=%h pway=%h done=%b we=%b want tw=1 pv=1 pidx=%h pway=%h",
                     tag_we_o, plru_valid_o, plru_index_o, plru_way_o, done_o, arr_we_o, idx, way);
        end
        step();

        #1;
        nchk++;
        if ({done_o, req_ready_o, tag_we_o, plru_valid_o} !== 4'b1000) begin
            nerr++;
            $display("FAIL done: got done=%b rdy=%b tw=%b pv=%b want 1000",
                     done_o, req_ready_o, tag_we_o, plru_valid_o);
        end
        step();

        #1;
        nchk++;
        if ({done_o, req_ready_o} !== 2'b01) begin
            nerr++;
            $display("FAIL back_idle: got done=%b rdy=%b want 01", done_o, req_ready_o);
        end
    endtask

    task automatic test_reset();
        #1;
        nchk++;
        if (req_ready_o !== 1'b1) begin
            nerr++;
            $display("FAIL reset_ready: got %b want 1", req_ready_o);
        end
        nchk++;
        if ({arr_index_o, arr_way_o, arr_beat_o, arr_we_o, arr_wdata_o, tag_we_o, mem_req_valid_o,
             mem_we_o, mem_addr_o, mem_wdata_o, plru_valid_o, plru_index_o, plru_way_o, done_o} !== '0) begin
            nerr++;
            $display("FAIL reset_outputs: got idx=%h way=%h ab=%h we=%b mv=%b addr=%h pv=%b done=%b want all 0",
                     arr_index_o, arr_way_o, arr_beat_o, arr_we_o, mem_req_valid_o, mem_addr_o,
                     plru_valid_o, done_o);
        end
        rst_i = 1'b0;
        step();
        nchk++;
        if ({req_ready_o, mem_req_valid_o, done_o} !== 3'b100) begin
            nerr++;
            $display("FAIL idle_hold: got rdy=%b mv=%b done=%b want 100", req_ready_o, mem_req_valid_o, done_o);
        end
    endtask

    task automatic test_clean_miss();
        do_miss(6'd5, 20'h12345, 2'd2, 1'b1, 1'b0, 20'h00777, -1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_dirty_miss();
        do_miss(6'd12, 20'hABCDE, 2'd1, 1'b1, 1'b1, 20'h0003A, -1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_pressure();
        do_miss(6'd33, 20'h55AA5, 2'd3, 1'b1, 1'b1, 20'h0F0F0, 2, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_gapped_rvalid();
        do_miss(6'd7, 20'h00042, 2'd0, 1'b1, 1'b0, 20'h11111, -1, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_invalid_dirty();
        do_miss(6'd63, 20'hFFFFF, 2'd2, 1'b0, 1'b1, 20'h22222, -1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_miss(6'd1, 20'h01010, 2'd1, 1'b1, 1'b0, 20'h0, -1, 1'b0, 1'b0, 1'b0);
        do_miss(6'd2, 20'h02020, 2'd3, 1'b1, 1'b1, 20'h00BAD, -1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_async_reset();
        mem_req_ready_i = 1'b1;
        req_valid_i     = 1'b1;
        req_index_i     = 6'd9;
        req_tag_i       = 20'h0BEEF;
        victim_way_i    = 2'd3;
        step();
        req_valid_i    = 1'b0;
        victim_valid_i = 1'b1;
        victim_dirty_i = 1'b0;
        step();
        step();
        for (int b = 0; b < 2; b++) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = 32'h5000_0000 + b;
            step();
        end
        mem_rdata_i = 32'h5000_0002;
        #1;
        nchk++;
        if ({arr_we_o, arr_beat_o} !== {1'b1, 2'd2}) begin
            nerr++;
            $display("FAIL pre_reset beat: got we=%b ab=%0d want we=1 ab=2", arr_we_o, arr_beat_o);
        end
        rst_i = 1'b1;
        #1;
        nchk++;
        if (req_ready_o !== 1'b1) begin
            nerr++;
            $display("FAIL async_ready: got %b want 1", req_ready_o);
        end
        nchk++;
        if ({arr_index_o, arr_way_o, arr_beat_o, arr_we_o, arr_wdata_o, tag_we_o, mem_req_valid_o,
             mem_we_o, mem_addr_o, mem_wdata_o, plru_valid_o, plru_index_o, plru_way_o, done_o} !== '0) begin
            nerr++;
            $display("FAIL async_outputs: got idx=%h way=%h ab=%h we=%b wd=%h mv=%b pv=%b done=%b want all 0",
                     arr_index_o, arr_way_o, arr_beat_o, arr_we_o, arr_wdata_o, mem_req_valid_o,
                     plru_valid_o, done_o);
        end
        mem_rvalid_i = 1'b0;
        for (int c = 0; c < 2; c++) begin
            step();
            nchk++;
            if ({tag_we_o, plru_valid_o, done_o, req_ready_o} !== 4'b0001) begin
                nerr++;
                $display("FAIL in_reset cycle %0d: got tw=%b pv=%b done=%b rdy=%b want 0001",
                         c, tag_we_o, plru_valid_o, done_o, req_ready_o);
            end
        end
        rst_i = 1'b0;
        step();
        do_miss(6'd9, 20'h0BEEF, 2'd3, 1'b1, 1'b0, 20'h0, -1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_i           = 1'b1;
        req_valid_i     = 1'b0;
        req_index_i     = '0;
        req_tag_i       = '0;
        victim_way_i    = '0;
        victim_valid_i  = 1'b0;
        victim_dirty_i  = 1'b0;
        victim_tag_i    = '0;
        wb_data_i       = '0;
        mem_req_ready_i = 1'b0;
        mem_rvalid_i    = 1'b0;
        mem_rdata_i     = '0;
        step();
        step();

        test_reset();
        test_clean_miss();
        test_dirty_miss();
        test_back_pressure();
        test_gapped_rvalid();
        test_async_reset();
        test_invalid_dirty();
        test_back_to_back();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

`default_nettype wire
